// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   - BCD digit constants used by the digit correction and the legality check
//   - FSM state encoding
//   - constant helper functions for sizing the counter and checking BIN_W
package bcd_to_binary_seq_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int BCD_CORR_THR  = 8;
    localparam int BCD_CORR_SUB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input longint unsigned v);
        int              r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Binary width needed to hold 10**digits - 1.
    function automatic int min_bin_w(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return clog2(p);
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle of the BCD-to-binary converter.
//   in_valid/in_ready/bcd_in        : input side (keypad digit entry)
//   out_valid/out_ready/bin_out/err/err_digit : result side (binary ALU)
// master = producer/consumer surrounding the converter, slave = the converter.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    logic [DIGITS-1:0]     err_digit;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err,
        input  err_digit
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err,
        output err_digit
    );

endinterface

// File: rtl/bcd_to_binary_seq_digit_corr.sv
// Reverse double-dabble correction of one BCD digit after the right shift:
// a digit that reached 8 or more gets 3 subtracted.
//   i_digit : shifted digit
//   o_digit : corrected digit
module bcd_to_binary_seq_digit_corr
    import bcd_to_binary_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(BCD_CORR_THR))
                   ? i_digit - BCD_DIGIT_W'(BCD_CORR_SUB)
                   : i_digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Multi-digit sequential BCD-to-binary converter (reverse double-dabble,
// one result bit per clock).
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : slave side of bcd_to_binary_seq_if (valid/ready on input and output)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for in_valid
// ST_SHIFT | converting, one shift+correct per clock, counter counts down
// ST_DONE  | out_valid high, result held until out_ready
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
)
(
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_binary_seq_if.slave    bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = clog2(BIN_W + 1);

    if (DIGITS < 1 || BIN_W < min_bin_w(DIGITS)) begin : g_cfg_err
        $error("bcd_to_binary_seq: BIN_W=%0d too small for DIGITS=%0d", BIN_W, DIGITS);
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    r_sr;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BIN_W-1:0]   r_bin_out;
    logic               r_err;
    logic [DIGITS-1:0]  r_err_digit;

    logic [DIGITS-1:0]  w_err_digit;
    logic [SR_W-1:0]    w_sr_shift;
    logic [SR_W-1:0]    w_sr_next;

    assign w_sr_shift              = r_sr >> 1;
    assign w_sr_next[BIN_W-1:0]    = w_sr_shift[BIN_W-1:0];

    // Per-digit legality check on the raw input and per-digit correction of the
    // shifted BCD part; digits are corrected independently, no borrow between them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_err_digit[g] =
            bus.bcd_in[g*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT);

        bcd_to_binary_seq_digit_corr u_corr (
            .i_digit (w_sr_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_sr_next [BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bin_out   <= '0;
            r_err       <= 1'b0;
            r_err_digit <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (|w_err_digit) begin
                            // Illegal input skips the conversion entirely.
                            r_bin_out   <= '0;
                            r_err       <= 1'b1;
                            r_err_digit <= w_err_digit;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sr    <= {bus.bcd_in, {BIN_W{1'b0}}};
                            r_cnt   <= CNT_W'(BIN_W);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_bin_out   <= w_sr_next[BIN_W-1:0];
                        r_err       <= 1'b0;
                        r_err_digit <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin_out;
    assign bus.err       = r_err;
    assign bus.err_digit = r_err_digit;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference conversion: plain decimal arithmetic on the digits.
    function automatic void ref_conv(input logic [11:0] b, output logic [9:0] v,
                                     output logic e, output logic [2:0] ed);
        int s;
        int d;
        int w;
        s  = 0;
        w  = 1;
        ed = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) ed[i] = 1'b1;
            s = s + d * w;
            w = w * 10;
        end
        e = |ed;
        v = e ? 10'd0 : 10'(s);
    endfunction

    // Transaction-level model: an accepted input becomes visible a fixed number
    // of edges later (BIN_W for legal, immediately for illegal) and stays until
    // the consumer takes it.
    int          cyc      = 0;
    bit          m_busy   = 1'b0;
    int          m_due    = 0;
    int          m_acc    = 0;
    logic [9:0]  m_bin_n  = '0;
    logic        m_err_n  = 1'b0;
    logic [2:0]  m_ed_n   = '0;
    logic [9:0]  m_bin    = '0;
    logic        m_err    = 1'b0;
    logic [2:0]  m_ed     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_bin  = '0;
            m_err  = 1'b0;
            m_ed   = '0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (bus.in_valid === 1'b1) begin
                    ref_conv(bus.bcd_in, m_bin_n, m_err_n, m_ed_n);
                    m_busy = 1'b1;
                    m_acc++;
                    m_due  = cyc + (m_err_n ? 0 : BIN_W);
                    if (m_err_n) begin
                        m_bin = m_bin_n;
                        m_err = m_err_n;
                        m_ed  = m_ed_n;
                    end
                end
            end else begin
                if (cyc == m_due) begin
                    m_bin = m_bin_n;
                    m_err = m_err_n;
                    m_ed  = m_ed_n;
                end
                if (cyc > m_due && bus.out_ready === 1'b1) m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  32'(bus.in_ready),  32'(!m_busy));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_busy && cyc >= m_due));
            chk("m_bin_out",   32'(bus.bin_out),   32'(m_bin));
            chk("m_err",       32'(bus.err),       32'(m_err));
            chk("m_err_digit", 32'(bus.err_digit), 32'(m_ed));
        end
    end

    // Waits (bounded) until the DUT is idle; leaves us at negedge+1.
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("wait_idle_timeout", 32'(n), 32'(0));
    endtask

    // One directed conversion with literal expectations and optional stall.
    task automatic directed(input string name, input logic [11:0] bcd,
                            input int exp_bin, input int exp_err, input int exp_ed,
                            input int exp_lat, input int stall);
        int   k;
        logic v;
        wait_idle();
        bus.in_valid  = 1'b1;
        bus.bcd_in    = bcd;
        bus.out_ready = 1'b0;
        @(negedge clk);
        k = 0;
        v = bus.out_valid;
        #1 bus.in_valid = 1'b0;
        while (v !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            v = bus.out_valid;
        end
        chk({name, "_latency"},   32'(k),             32'(exp_lat));
        chk({name, "_bin"},       32'(bus.bin_out),   32'(exp_bin));
        chk({name, "_err"},       32'(bus.err),       32'(exp_err));
        chk({name, "_err_digit"}, 32'(bus.err_digit), 32'(exp_ed));
        #1;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = (s % 2 == 0);
            bus.bcd_in   = 12'h123;
            @(negedge clk);
            chk({name, "_stall_valid"}, 32'(bus.out_valid), 32'(1));
            chk({name, "_stall_bin"},   32'(bus.bin_out),   32'(exp_bin));
            chk({name, "_stall_ready"}, 32'(bus.in_ready),  32'(0));
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_release_valid"}, 32'(bus.out_valid), 32'(0));
        chk({name, "_release_ready"}, 32'(bus.in_ready),  32'(1));
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        int          guard;
        int          start_acc;
        logic [11:0] b;

        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_bin_out",   32'(bus.bin_out),   32'(0));
        chk("rst_err",       32'(bus.err),       32'(0));
        chk("rst_err_digit", 32'(bus.err_digit), 32'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        directed("d999", 12'h999, 999, 0, 0, 10, 0);
        directed("d000", 12'h000,   0, 0, 0, 10, 0);
        directed("d001", 12'h001,   1, 0, 0, 10, 0);
        directed("d512", 12'h512, 512, 0, 0, 10, 0);
        directed("d100", 12'h100, 100, 0, 0, 10, 0);
        directed("dA3F", 12'hA3F,   0, 1, 5,  0, 0);
        directed("d255", 12'h255, 255, 0, 0, 10, 5);

        // Reset during the fourth SHIFT cycle discards the conversion.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h317;
        @(negedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_result", 32'(bus.out_valid), 32'(0));
        #1;
        directed("d042", 12'h042, 42, 0, 0, 10, 0);

        // Random back-to-back traffic, checked every cycle against the model.
        start_acc = m_acc;
        guard     = 0;
        while (m_acc < start_acc + 1000 && guard < 60000) begin
            if ($urandom_range(0, 1) == 0) begin
                b = '0;
                for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
            end else begin
                b = 12'($urandom);
            end
            bus.bcd_in    = b;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 60000) chk("random_timeout", 32'(m_acc - start_acc), 32'(1000));

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_idle", 32'(bus.in_ready), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
